// File: rtl/lake_spec.sv
// Lake memory tile: one scheduled write port and one scheduled read port driven off a shared cycle counter.
// Optional macro WRITE_BYPASS_EN: a same-cycle, same-address read returns the incoming write data.
module lake_spec #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 512,
    parameter int NUM_DIMS   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [549:0]          config_memory_size_550,
    input  logic [DATA_WIDTH-1:0] port_0,
    output logic [DATA_WIDTH-1:0] port_1
);

    localparam int AW        = $clog2(MEM_DEPTH);
    localparam int PORT_BITS = 228;

    logic [15:0]               cycle_cnt;
    logic [1:0]                fire_v;
    logic [1:0][AW-1:0]        addr_v;
    logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]     rd_data;

    // Reserved configuration bits carry no meaning.
    logic unused_cfg;
    assign unused_cfg = ^config_memory_size_550[549:2*PORT_BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (flush) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    // Port 0 is the write port, port 1 the read port; both share one generator shape.
    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int BASE = p * PORT_BITS;

        logic        en;
        logic [3:0]  act;
        logic [15:0] ext  [NUM_DIMS];
        logic [15:0] astr [NUM_DIMS];
        logic [15:0] sstr [NUM_DIMS];
        logic [15:0] aoff;
        logic [15:0] soff;
        logic [15:0] it_q [NUM_DIMS];
        logic [15:0] it_d [NUM_DIMS];
        logic        done_q;
        logic        done_d;
        logic [15:0] sched;
        logic [15:0] addr;
        logic        fire;
        logic        carry;
        logic        unused_addr_hi;

        always_comb begin
            en   = config_memory_size_550[BASE];
            aoff = config_memory_size_550[BASE+132 +: 16];
            soff = config_memory_size_550[BASE+212 +: 16];
            case (config_memory_size_550[BASE+1 +: 3])
                3'd0, 3'd1: act = 4'b0001;
                3'd2:       act = 4'b0011;
                3'd3:       act = 4'b0111;
                default:    act = 4'b1111;
            endcase
            for (int k = 0; k < NUM_DIMS; k++) begin
                ext[k]  = config_memory_size_550[BASE+4+16*k +: 16];
                astr[k] = config_memory_size_550[BASE+68+16*k +: 16];
                sstr[k] = config_memory_size_550[BASE+148+16*k +: 16];
                if (ext[k] == 16'd0) begin
                    ext[k] = 16'd1;
                end
            end
        end

        always_comb begin
            sched = soff;
            addr  = aoff;
            for (int k = 0; k < NUM_DIMS; k++) begin
                if (act[k]) begin
                    sched = sched + 16'(it_q[k] * sstr[k]);
                    addr  = addr + 16'(it_q[k] * astr[k]);
                end
            end
        end

        assign fire = en && !done_q && !flush && (cycle_cnt == sched);

        // Odometer step: a carry out of the outermost active dimension ends the port.
        always_comb begin
            it_d   = it_q;
            done_d = done_q;
            carry  = fire;
            for (int k = 0; k < NUM_DIMS; k++) begin
                if (act[k] && carry) begin
                    if (it_q[k] == ext[k] - 16'd1) begin
                        it_d[k] = '0;
                    end else begin
                        it_d[k] = it_q[k] + 16'd1;
                        carry   = 1'b0;
                    end
                end
            end
            if (carry) begin
                done_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < NUM_DIMS; k++) it_q[k] <= '0;
                done_q <= 1'b0;
            end else if (flush) begin
                for (int k = 0; k < NUM_DIMS; k++) it_q[k] <= '0;
                done_q <= 1'b0;
            end else begin
                it_q   <= it_d;
                done_q <= done_d;
            end
        end

        assign fire_v[p]      = fire;
        assign addr_v[p]      = addr[AW-1:0];
        assign unused_addr_hi = ^addr[15:AW];
    end

    always_ff @(posedge clk) begin
        if (fire_v[0]) begin
            mem[addr_v[0]] <= port_0;
        end
    end

    always_comb begin
        rd_data = mem[addr_v[1]];
`ifdef WRITE_BYPASS_EN
        if (fire_v[0] && (addr_v[0] == addr_v[1])) begin
            rd_data = port_0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_1 <= '0;
        end else if (fire_v[1]) begin
            port_1 <= rd_data;
        end
    end

endmodule

// File: tb/tb_lake_spec.sv
// Bench for lake_spec: directed scenarios plus randomized configurations, checked against
// an event-list model that enumerates each port's iteration domain.
module tb_lake_spec;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [549:0] cfg;
    logic [15:0]  port_0;
    logic [15:0]  port_1;

    always #5 clk = ~clk;

    lake_spec dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .flush                  (flush),
        .config_memory_size_550 (cfg),
        .port_0                 (port_0),
        .port_1                 (port_1)
    );

    typedef struct packed {
        logic [15:0] t;
        logic [8:0]  a;
    } ev_t;

    // Per-port configuration (0 = write, 1 = read)
    bit          p_en   [2];
    logic [2:0]  p_dim  [2];
    logic [15:0] p_ext  [2][4];
    logic [15:0] p_ast  [2][4];
    logic [15:0] p_sst  [2][4];
    logic [15:0] p_aoff [2];
    logic [15:0] p_soff [2];

    // Reference model state
    ev_t         wq[$];
    ev_t         rq[$];
    int          wi;
    int          ri;
    logic [15:0] mem_m [512];
    bit          mem_v [512];
    logic [15:0] exp_q[$];
    logic [15:0] exp_p1;
    bit          exp_known;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic clear_port(input int p);
        p_en[p]   = 1'b1;
        p_dim[p]  = 3'd1;
        p_aoff[p] = '0;
        p_soff[p] = '0;
        for (int k = 0; k < 4; k++) begin
            p_ext[p][k] = '0;
            p_ast[p][k] = '0;
            p_sst[p][k] = '0;
        end
    endtask

    task automatic pack_cfg();
        int b;
        cfg = '0;
        for (int p = 0; p < 2; p++) begin
            b = p * 228;
            cfg[b]         = p_en[p];
            cfg[b+1 +: 3]  = p_dim[p];
            cfg[b+132 +: 16] = p_aoff[p];
            cfg[b+212 +: 16] = p_soff[p];
            for (int k = 0; k < 4; k++) begin
                cfg[b+4+16*k +: 16]   = p_ext[p][k];
                cfg[b+68+16*k +: 16]  = p_ast[p][k];
                cfg[b+148+16*k +: 16] = p_sst[p][k];
            end
        end
    endtask

    // Enumerate the iteration domain in firing order as (time, address) events.
    task automatic build_ev(input int p);
        int   d;
        int   total;
        int   rem;
        int   e   [4];
        int   idx [4];
        logic [15:0] tt;
        logic [15:0] aa;
        ev_t  ev;
        ev_t  q[$];
        case (p_dim[p])
            3'd0, 3'd1: d = 1;
            3'd2:       d = 2;
            3'd3:       d = 3;
            default:    d = 4;
        endcase
        total = 1;
        for (int k = 0; k < 4; k++) begin
            e[k] = (k < d) ? ((p_ext[p][k] == 0) ? 1 : int'(p_ext[p][k])) : 1;
            total = total * e[k];
        end
        if (p_en[p]) begin
            for (int n = 0; n < total; n++) begin
                rem = n;
                tt  = p_soff[p];
                aa  = p_aoff[p];
                for (int k = 0; k < 4; k++) begin
                    idx[k] = rem % e[k];
                    rem    = rem / e[k];
                    tt     = tt + 16'(idx[k] * p_sst[p][k]);
                    aa     = aa + 16'(idx[k] * p_ast[p][k]);
                end
                ev.t = tt;
                ev.a = aa[8:0];
                q.push_back(ev);
            end
        end
        if (p == 0) wq = q;
        else        rq = q;
    endtask

    task automatic restart();
        flush = 1'b1;
        pack_cfg();
        build_ev(0);
        build_ev(1);
        wi = 0;
        ri = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (exp_known) check("flush_hold", port_1, exp_p1);
        end
    endtask

    // mode 0: data 2t, mode 1: data 2t+1, otherwise random
    task automatic run(input int n, input int mode, input string tag);
        logic [15:0] d;
        logic [8:0]  ra;
        bit          fw;
        bit          fr;
        bit          byp;
        byp = 1'b0;
`ifdef WRITE_BYPASS_EN
        byp = 1'b1;
`endif
        flush = 1'b0;
        for (int t = 0; t < n; t++) begin
            case (mode)
                0:       d = 16'(2 * t);
                1:       d = 16'(2 * t + 1);
                default: d = 16'($urandom);
            endcase
            port_0 = d;
            fw = (wi < wq.size()) && (wq[wi].t == 16'(t));
            fr = (ri < rq.size()) && (rq[ri].t == 16'(t));
            if (fr) begin
                ra = rq[ri].a;
                ri++;
                if (byp && fw && (wq[wi].a == ra)) begin
                    exp_p1    = d;
                    exp_known = 1'b1;
                end else begin
                    exp_p1    = mem_m[ra];
                    exp_known = mem_v[ra];
                end
            end
            if (fw) begin
                mem_m[wq[wi].a] = d;
                mem_v[wq[wi].a] = 1'b1;
                wi++;
            end
            exp_q.push_back(exp_p1);
            @(posedge clk);
            #1;
            if (exp_known) check(tag, port_1, exp_q.pop_front());
            else void'(exp_q.pop_front());
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        flush  = 1'b1;
        port_0 = '0;
        cfg    = '0;
        for (int a = 0; a < 512; a++) mem_v[a] = 1'b0;

        // Reset, then armed ports held off by flush
        repeat (4) @(posedge clk);
        #1;
        check("reset_port_1", port_1, 16'd0);
        clear_port(0);
        clear_port(1);
        p_ext[0][0] = 16'd4; p_sst[0][0] = 16'd1; p_ast[0][0] = 16'd1;
        p_ext[1][0] = 16'd4; p_sst[1][0] = 16'd1; p_ast[1][0] = 16'd1;
        pack_cfg();
        rst_n = 1'b1;
        exp_p1 = '0;
        exp_known = 1'b1;
        for (int c = 0; c < 16; c++) begin
            port_0 = 16'($urandom);
            @(posedge clk);
            #1;
            check("flush_idle", port_1, 16'd0);
        end

        // Linear buffer
        clear_port(0);
        clear_port(1);
        p_ext[0][0] = 16'd64; p_ast[0][0] = 16'd1; p_sst[0][0] = 16'd1;
        p_ext[1][0] = 16'd64; p_ast[1][0] = 16'd1; p_sst[1][0] = 16'd1;
        p_soff[1] = 16'd64;
        restart();
        run(140, 0, "linear");
        check("linear_hold", port_1, 16'd126);

        // Done, flush, rerun with new data
        restart();
        run(140, 1, "rerun");
        check("rerun_hold", port_1, 16'd127);

        // 2-D transpose
        clear_port(0);
        clear_port(1);
        p_dim[0] = 3'd2; p_dim[1] = 3'd2;
        p_ext[0][0] = 16'd8; p_ext[0][1] = 16'd8;
        p_ext[1][0] = 16'd8; p_ext[1][1] = 16'd8;
        p_ast[0][0] = 16'd1; p_ast[0][1] = 16'd8;
        p_ast[1][0] = 16'd8; p_ast[1][1] = 16'd1;
        p_sst[0][0] = 16'd1; p_sst[0][1] = 16'd8;
        p_sst[1][0] = 16'd1; p_sst[1][1] = 16'd8;
        p_soff[1] = 16'd64;
        restart();
        run(140, 2, "transpose");

        // Same-cycle collision at address 0
        clear_port(0);
        clear_port(1);
        restart();
        run(4, 2, "collision");

        // Address wrap 510, 511, 0, 1
        clear_port(0);
        clear_port(1);
        p_ext[0][0] = 16'd4; p_ast[0][0] = 16'd1; p_sst[0][0] = 16'd1; p_aoff[0] = 16'd510;
        p_ext[1][0] = 16'd4; p_ast[1][0] = 16'd1; p_sst[1][0] = 16'd1; p_aoff[1] = 16'd510;
        p_soff[1] = 16'd8;
        restart();
        run(20, 2, "addr_wrap");

        // Read port disabled
        p_en[1] = 1'b0;
        p_ext[0][0] = 16'd64; p_aoff[0] = 16'd0;
        restart();
        run(80, 2, "read_off");

        // Randomized configurations
        for (int it = 0; it < 6; it++) begin
            for (int p = 0; p < 2; p++) begin
                clear_port(p);
                p_en[p]   = ($urandom_range(0, 7) != 0);
                p_dim[p]  = 3'($urandom_range(0, 7));
                p_aoff[p] = 16'($urandom);
                for (int k = 0; k < 4; k++) begin
                    p_ext[p][k] = 16'($urandom_range(0, 3));
                    p_ast[p][k] = 16'($urandom_range(0, 40));
                    p_sst[p][k] = 16'($urandom_range(0, 6));
                end
            end
            p_soff[0] = 16'($urandom_range(0, 5));
            p_soff[1] = 16'($urandom_range(0, 60));
            restart();
            run(150, 2, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
